// File: rtl/divider_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_scheduler_pkg
// Brief    : Shared state encoding and constants for the divider scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package divider_scheduler_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Divide-by-zero result; callers slice off the low WIDTH bits (all ones)
  localparam logic [63:0] DIV0_ONES = '1;

endpackage : divider_scheduler_pkg
`default_nettype wire

// File: rtl/divider_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : divider_scheduler_rr_pick
// Brief    : Combinational round-robin picker. Searches req_i upward from
//            ptr_i, wrapping modulo NREQ, and reports the first set bit.
// Revision : 1.0 - initial release
// ============================================================================
module divider_scheduler_rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] winner_o,
  output logic             found_o
);

  // One extra bit so ptr + offset cannot overflow before the wrap
  logic [PTR_W:0] idx;

  // Priority scan starting at ptr_i; the first hit wins
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_i} + (PTR_W+1)'(i);
      // ptr_i < NREQ, so one subtraction is enough to wrap
      if (idx >= (PTR_W+1)'(NREQ)) begin
        idx = idx - (PTR_W+1)'(NREQ);
      end
      if (!found_o && req_i[idx[PTR_W-1:0]]) begin
        found_o  = 1'b1;
        winner_o = idx[PTR_W-1:0];
      end
    end
  end

endmodule : divider_scheduler_rr_pick
`default_nettype wire

// File: rtl/divider_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : divider_scheduler
// Brief    : Time-shares one fixed-latency divider among NREQ requesters
//            with round-robin grant. Divide-by-zero bypasses the divider
//            and returns all ones. Completion is a one-hot, one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================
module divider_scheduler
  import divider_scheduler_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NREQ        = 4,
  parameter int DIV_LATENCY = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  output logic [NREQ-1:0]        done,
  output logic [WIDTH-1:0]       res_q,
  output logic                   busy,
  output logic [WIDTH-1:0]       div_a,
  output logic [WIDTH-1:0]       div_b,
  input  logic [WIDTH-1:0]       div_q
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  localparam logic [NREQ-1:0]  ONE_HOT   = NREQ'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV_LATENCY - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NREQ - 1);
  localparam logic [WIDTH-1:0] RES_DIV0  = DIV0_ONES[WIDTH-1:0];

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NREQ-1:0]    done_q;
  logic               busy_q;
  logic [WIDTH-1:0]   div_a_q;
  logic [WIDTH-1:0]   div_b_q;

  logic [PTR_W-1:0]   winner;
  logic               found;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  divider_scheduler_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  // Operands of the current round-robin winner
  assign sel_a = req_a[winner*WIDTH +: WIDTH];
  assign sel_b = req_b[winner*WIDTH +: WIDTH];

  assign done  = done_q;
  assign busy  = busy_q;
  assign div_a = div_a_q;
  assign div_b = div_b_q;

  // Scheduler FSM: grant, wait out the divider latency, pulse done
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      res_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
    end else begin
      // done is a single-cycle pulse unless re-armed below
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            id_q   <= winner;
            ptr_q  <= (winner == PTR_LAST) ? '0 : winner + 1'b1;
            busy_q <= 1'b1;
            if (sel_b == '0) begin
              // Zero divisor: answer immediately, leave the divider alone
              res_q   <= RES_DIV0;
              done_q  <= ONE_HOT << winner;
              state_q <= DONE;
            end else begin
              div_a_q <= sel_a;
              div_b_q <= sel_b;
              cnt_q   <= '0;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            res_q   <= div_q;
            done_q  <= ONE_HOT << id_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : divider_scheduler
`default_nettype wire

// File: doc/divider_scheduler.md
Name: divider_scheduler

Overview:
- Time-shares one small_divider instance among NREQ requesters (e.g. animation_renderer timing math, column-period calculation).
- Round-robin grant; drives the divider operands and waits a fixed latency for the quotient.
- Returns the quotient with a one-cycle done pulse to the granted requester.
- Division by zero bypasses the divider.

Parameters:
WIDTH, 8, operand/quotient width; must match the divider's WIDTH.
NREQ, 4, number of requesters, 2..8.
DIV_LATENCY, 8, cycles from stable operands to valid div_q, >=1.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request; held high with operands stable until done
req_a  in  NREQ*WIDTH  dividends; requester i occupies bits [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  divisors, same packing
done  out  NREQ  one-hot, one-cycle completion pulse
res_q  out  WIDTH  quotient; valid while done is nonzero, held until the next completion
busy  out  1  high in BUSY and DONE
div_a  out  WIDTH  registered dividend to small_divider
div_b  out  WIDTH  registered divisor to small_divider
div_q  in  WIDTH  quotient from small_divider

Behaviour:
- Reset values (async, reset_n low):
  - state=IDLE, done=0, res_q=0, busy=0, div_a=0, div_b=0, cnt=0, ptr=0.
- States are IDLE, BUSY and DONE.
- Grant rule in IDLE:
  - Search req starting at index ptr, ascending, wrapping modulo NREQ.
  - The first set bit is the winner w; if no bit is set, stay in IDLE.
- Grant edge k:
  - Latch id=w and set ptr=(w+1) mod NREQ.
  - If req_b[w]==0: res_q=all ones, go to DONE. done[w] is high in cycle k+1. div_a and div_b are unchanged.
  - Otherwise: div_a=req_a[w], div_b=req_b[w], cnt=0, go to BUSY.
- BUSY:
  - cnt increments on each edge.
  - On the edge where cnt==DIV_LATENCY-1, res_q=div_q and the state goes to DONE.
  - done[id] is high in cycle k+DIV_LATENCY+1.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - A new grant can occur at the first edge in IDLE.
  - Normal throughput is one operation per DIV_LATENCY+2 cycles.
- Requester obligations:
  - Keep req and operands stable from assertion through the done cycle.
  - Deassert req in the cycle after its done; a req still high then counts as a new request.
- req changes during BUSY or DONE are ignored; operands were already latched.
- div_a and div_b hold their last values while IDLE. No divider start strobe exists.
- Arithmetic: unsigned, quotient truncated (floor). The divide-by-zero result is 2^WIDTH-1.
- Reset asserted mid-operation aborts immediately:
  - No done pulse for the aborted operation.
  - Requesters must re-request after reset release.
- Simultaneous requests: only the winner is served; the others stay pending and are served in later rounds in rotating order.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the all-ones divide-by-zero result constant.
- One natural sub-module, rr_pick:
  - combinational round-robin priority picker;
  - inputs req and ptr; outputs winner index and found flag;
  - parameterised by NREQ.

Test Plan (WIDTH=8, NREQ=4, DIV_LATENCY=8, real small_divider attached):
- req[0], a=123, b=5, grant at edge k -> done=4'b0001 in cycle k+9, res_q=24.
- req=4'b1111 held; each requester drops req after its done -> dones in order 0,1,2,3, 10 cycles apart, each quotient correct.
- req[2], a=77, b=0 -> done[2] in cycle k+1, res_q=255, div_a/div_b unchanged.
- Fairness: after req0 is served (ptr=1), req0 and req2 are both high -> req2 is granted first, then req0.
- Reset pulse on the 4th BUSY cycle -> done stays 0; busy, div_a, div_b and res_q are 0; ptr=0; a fresh req[1] afterwards completes normally.
- Boundary values: a=255 b=1 -> 255; a=1 b=5 -> 0; a=0 b=10 -> 0; a=8 b=4 -> 2.
